key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
- Debounces the raw active-low push-button pins before they reach the basic key & display unit's Keys input.
- Removes contact bounce so that unit's edge detector sees exactly one press edge and one release edge per physical actuation.
- Also exports single-cycle press/release pulses for other consumers.
- Sits in the I/O clock domain, between the board pins and the key & display block.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- TICK_DIV, 15000, Clock cycles per sample tick (1 ms at 15 MHz); must be >= 2.
- DEBOUNCE_TICKS, 10, consecutive ticks a new level must persist before it is accepted; must be >= 1.

Ports:
- Clock  input  1  I/O logic clock.
- Reset  input  1  synchronous, active-low reset; sampled on posedge Clock only.
- Enable  input  1  1 = debounce active; 0 = all channels forced released.
- KeysRaw  input  NUM_KEYS  raw pins, asynchronous; 0 = pressed, 1 = released.
- KeysClean  output  NUM_KEYS  debounced level, same polarity as KeysRaw; feeds the key & display unit's Keys input.
- PressPulse  output  NUM_KEYS  1-cycle pulse on accepted 1->0 transition.
- ReleasePulse  output  NUM_KEYS  1-cycle pulse on accepted 0->1 transition.

Behaviour:
- Reset (Reset=0 at posedge):
  - sync flops = all 1; prescaler = 0; every channel in ST_RELEASED with count = 0.
  - KeysClean = all 1; PressPulse = 0; ReleasePulse = 0.
  - Reset asserted mid-debounce aborts it with no pulse.
- Synchronizer: 2 flops per key, reset value 1. The FSM sees KeysRaw 2 cycles late (Sync).
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps.
  - Tick = 1 for the single cycle when count == TICK_DIV-1.
  - free-running; shared by all channels.
  - held at 0 while Enable = 0.
- Per-channel FSM (all outputs registered), states ST_RELEASED, ST_PRESS_WAIT, ST_PRESSED, ST_RELEASE_WAIT:
  - ST_RELEASED: KeysClean=1. Sync=0 -> ST_PRESS_WAIT, count=0.
  - ST_PRESS_WAIT: KeysClean=1.
    - Sync=1 -> ST_RELEASED, count=0, no pulse (bounce rejected).
    - Sync=0 & Tick & count==DEBOUNCE_TICKS-1 -> ST_PRESSED; KeysClean=0 and PressPulse=1 on the same edge.
    - Sync=0 & Tick otherwise -> count+1.
  - ST_PRESSED: KeysClean=0. Sync=1 -> ST_RELEASE_WAIT, count=0.
  - ST_RELEASE_WAIT: mirror of ST_PRESS_WAIT. Sync=0 -> ST_PRESSED; acceptance -> ST_RELEASED with KeysClean=1 and ReleasePulse=1.
- Priority and pulses:
  - A level revert on the same cycle as the final Tick wins: no transition.
  - Pulses are high for exactly one cycle; otherwise 0.
- Latency: KeysRaw change to KeysClean change is 3 + (1..TICK_DIV) + (DEBOUNCE_TICKS-1)*TICK_DIV cycles, depending on prescaler phase.
- Counter width: $clog2(DEBOUNCE_TICKS+1); it never wraps because acceptance occurs at DEBOUNCE_TICKS-1.
- Channels are independent; simultaneous acceptance on several keys gives simultaneous pulses.
- Enable = 0:
  - at next edge all channels go to ST_RELEASED, count=0, KeysClean = all 1, no pulses (including none for a key that was pressed).
  - the sync flops keep running.
  - on Enable 0->1 with a key held, that key starts a fresh press debounce.

Decomposition:
- Package KeyDebounce_Pkg:
  - typedef enum logic[1:0] KeyDbState_t {ST_RELEASED, ST_PRESS_WAIT, ST_PRESSED, ST_RELEASE_WAIT};
  - default constants KD_TICK_DIV=15000 and KD_DEBOUNCE_TICKS=10.
- Sub-module key_debounce_channel, one per key via generate. It holds the FSM, tick counter and output flops, with inputs Clock, Reset, Enable, Tick, Sync.
- Top level holds the synchronizers, the prescaler and the generate loop.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3, NUM_KEYS=4, Enable=1 unless noted):
- Reset, then release Reset with KeysRaw=4'hF -> KeysClean=4'hF, PressPulse=ReleasePulse=0 for 50 cycles.
- KeysRaw[0] 1->0, held -> KeysClean[0] falls 12..15 cycles later; PressPulse[0]=1 for exactly 1 cycle on that edge; other bits unchanged.
- KeysRaw[1] toggles 0/1 every 5 cycles for 60 cycles, then stays 1 -> KeysClean[1] stays 1; no PressPulse[1] or ReleasePulse[1].
- Key 2 pressed and accepted, then released and held 1 -> KeysClean[2] rises 12..15 cycles after release; ReleasePulse[2] is a single 1-cycle pulse.
- Keys 0 and 3 pressed on the same cycle -> PressPulse=4'b1001 in one cycle, KeysClean=4'b0110.
- Key 0 held pressed and accepted, then Enable=0 -> next cycle KeysClean[0]=1 with no pulse; Enable=1 -> PressPulse[0] after a fresh 12..15-cycle debounce.
- Reset=0 asserted during ST_PRESS_WAIT -> after next edge all outputs at reset values; no pulse.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Holds the per-channel FSM state encoding, the default timing constants
// and the width helpers used to size the prescaler and the tick counter.
package KeyDebounce_Pkg;

  // Per-channel debounce states; the two *_WAIT states hold a candidate level.
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } KeyDbState_t;

  // 1 ms sample tick at a 15 MHz I/O clock.
  localparam int KD_TICK_DIV       = 15000;
  // A new level must survive this many ticks before it is accepted.
  localparam int KD_DEBOUNCE_TICKS = 10;

  // Width of the per-channel tick counter; acceptance happens at
  // DEBOUNCE_TICKS-1, so the counter can never wrap.
  function automatic int kdCountWidth(input int ticks);
    int w;
    if (ticks < 1) begin
      w = 1;
    end else begin
      w = $clog2(ticks + 1);
    end
    return w;
  endfunction

  // Width of the shared prescaler counting 0..div-1.
  function automatic int kdPrescaleWidth(input int div);
    int w;
    if (div < 2) begin
      w = 1;
    end else begin
      w = $clog2(div);
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key bus between the board-pin side and the key & display side.
// The debouncer is the slave: it takes the raw pins and enable, and
// returns the clean levels plus the single-cycle press/release pulses.
interface key_debouncer_if #(
  parameter int NUM_KEYS = 4
);

  logic                Enable;
  logic [NUM_KEYS-1:0] KeysRaw;
  logic [NUM_KEYS-1:0] KeysClean;
  logic [NUM_KEYS-1:0] PressPulse;
  logic [NUM_KEYS-1:0] ReleasePulse;

  modport master (
    output Enable,
    output KeysRaw,
    input  KeysClean,
    input  PressPulse,
    input  ReleasePulse
  );

  modport slave (
    input  Enable,
    input  KeysRaw,
    output KeysClean,
    output PressPulse,
    output ReleasePulse
  );

endinterface

// File: rtl/key_debouncer_channel.sv
// One debounce channel: FSM, tick counter and registered outputs.
// Sync is the already-synchronised pin (0 = pressed). A new level is accepted
// only after it has been seen on DEBOUNCE_TICKS consecutive sample ticks;
// any revert, even on the final tick, drops back without a pulse.
module key_debounce_channel
  import KeyDebounce_Pkg::*;
#(
  parameter int DEBOUNCE_TICKS = KD_DEBOUNCE_TICKS
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Tick,
  input  logic Sync,
  output logic KeysClean,
  output logic PressPulse,
  output logic ReleasePulse
);

  localparam int CNT_W = kdCountWidth(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  KeyDbState_t      state_r;
  KeyDbState_t      stateNext_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] countNext_s;
  logic             clean_r;
  logic             cleanNext_s;
  logic             press_r;
  logic             pressNext_s;
  logic             release_r;
  logic             releaseNext_s;

  // State, counter and output registers; reset aborts any debounce silently.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r   <= ST_RELEASED;
      count_r   <= '0;
      clean_r   <= 1'b1;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      count_r   <= countNext_s;
      clean_r   <= cleanNext_s;
      press_r   <= pressNext_s;
      release_r <= releaseNext_s;
    end
  end

  // Next-state, counter and next output values; a revert beats the final tick.
  always_comb begin
    stateNext_s   = state_r;
    countNext_s   = count_r;
    cleanNext_s   = clean_r;
    pressNext_s   = 1'b0;
    releaseNext_s = 1'b0;

    if (!Enable) begin
      // Disabled: everything reads as released, no pulse even for a held key.
      stateNext_s = ST_RELEASED;
      countNext_s = '0;
      cleanNext_s = 1'b1;
    end else begin
      case (state_r)
        ST_RELEASED: begin
          cleanNext_s = 1'b1;
          if (!Sync) begin
            stateNext_s = ST_PRESS_WAIT;
            countNext_s = '0;
          end else begin
            stateNext_s = ST_RELEASED;
          end
        end

        ST_PRESS_WAIT: begin
          cleanNext_s = 1'b1;
          if (Sync) begin
            stateNext_s = ST_RELEASED;
            countNext_s = '0;
          end else if (Tick) begin
            if (count_r == CNT_LAST) begin
              stateNext_s = ST_PRESSED;
              countNext_s = '0;
              cleanNext_s = 1'b0;
              pressNext_s = 1'b1;
            end else begin
              countNext_s = count_r + CNT_ONE;
            end
          end else begin
            stateNext_s = ST_PRESS_WAIT;
          end
        end

        ST_PRESSED: begin
          cleanNext_s = 1'b0;
          if (Sync) begin
            stateNext_s = ST_RELEASE_WAIT;
            countNext_s = '0;
          end else begin
            stateNext_s = ST_PRESSED;
          end
        end

        ST_RELEASE_WAIT: begin
          cleanNext_s = 1'b0;
          if (!Sync) begin
            stateNext_s = ST_PRESSED;
            countNext_s = '0;
          end else if (Tick) begin
            if (count_r == CNT_LAST) begin
              stateNext_s   = ST_RELEASED;
              countNext_s   = '0;
              cleanNext_s   = 1'b1;
              releaseNext_s = 1'b1;
            end else begin
              countNext_s = count_r + CNT_ONE;
            end
          end else begin
            stateNext_s = ST_RELEASE_WAIT;
          end
        end

        default: begin
          stateNext_s = ST_RELEASED;
          countNext_s = '0;
          cleanNext_s = 1'b1;
        end
      endcase
    end
  end

  assign KeysClean    = clean_r;
  assign PressPulse   = press_r;
  assign ReleasePulse = release_r;

endmodule

// File: rtl/key_debouncer_checker.sv
// Output-relationship properties of the debouncer, kept out of the datapath.
// A pulse must agree with the clean level it announces, press and release
// never coincide on one key, and a pulse never lasts more than one cycle.
module key_debouncer_checker #(
  parameter int NUM_KEYS = 4
) (
  input logic                Clock,
  input logic                Reset,
  input logic [NUM_KEYS-1:0] KeysClean,
  input logic [NUM_KEYS-1:0] PressPulse,
  input logic [NUM_KEYS-1:0] ReleasePulse
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gKeyProps
    aPressLevel: assert property (@(posedge Clock) disable iff (!Reset)
      PressPulse[k] |-> !KeysClean[k]);
    aReleaseLevel: assert property (@(posedge Clock) disable iff (!Reset)
      ReleasePulse[k] |-> KeysClean[k]);
    aNoBoth: assert property (@(posedge Clock) disable iff (!Reset)
      !(PressPulse[k] && ReleasePulse[k]));
    aPressOneCycle: assert property (@(posedge Clock) disable iff (!Reset)
      PressPulse[k] |=> !PressPulse[k]);
    aReleaseOneCycle: assert property (@(posedge Clock) disable iff (!Reset)
      ReleasePulse[k] |=> !ReleasePulse[k]);
  end

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer for the I/O clock domain.
// Two-flop synchronisers per pin, one shared free-running sample prescaler,
// and one debounce channel per key feeding the key & display unit.
module key_debouncer
  import KeyDebounce_Pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int TICK_DIV       = KD_TICK_DIV,
  parameter int DEBOUNCE_TICKS = KD_DEBOUNCE_TICKS
) (
  input  logic           Clock,
  input  logic           Reset,
  key_debouncer_if.slave keyIf
);

  localparam int PRE_W = kdPrescaleWidth(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [NUM_KEYS-1:0] syncStage1_r;
  logic [NUM_KEYS-1:0] syncStage2_r;
  logic [PRE_W-1:0]    prescale_r;
  logic                tick_s;
  logic [NUM_KEYS-1:0] cleanBits_s;
  logic [NUM_KEYS-1:0] pressBits_s;
  logic [NUM_KEYS-1:0] releaseBits_s;

  // Two-stage synchroniser for the asynchronous pins; idles at released (1).
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      syncStage1_r <= '1;
      syncStage2_r <= '1;
    end else begin
      syncStage1_r <= keyIf.KeysRaw;
      syncStage2_r <= syncStage1_r;
    end
  end

  // Shared sample prescaler; parked at 0 while the block is disabled.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      prescale_r <= '0;
    end else if (!keyIf.Enable) begin
      prescale_r <= '0;
    end else if (prescale_r == PRE_LAST) begin
      prescale_r <= '0;
    end else begin
      prescale_r <= prescale_r + PRE_ONE;
    end
  end

  assign tick_s = (prescale_r == PRE_LAST);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gChannel
    key_debounce_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) uChannel (
      .Clock        (Clock),
      .Reset        (Reset),
      .Enable       (keyIf.Enable),
      .Tick         (tick_s),
      .Sync         (syncStage2_r[k]),
      .KeysClean    (cleanBits_s[k]),
      .PressPulse   (pressBits_s[k]),
      .ReleasePulse (releaseBits_s[k])
    );
  end

  assign keyIf.KeysClean    = cleanBits_s;
  assign keyIf.PressPulse   = pressBits_s;
  assign keyIf.ReleasePulse = releaseBits_s;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with TICK_DIV=4, DEBOUNCE_TICKS=3.
// A timing-level reference model (sample ticks counted while a differing
// level persists) is compared every cycle; directed tables and sequences
// pin down exact latencies, pulse widths, enable and reset behaviour.
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int TD = 4;
  localparam int DT = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  key_debouncer_if #(.NUM_KEYS(NK)) kIf ();

  key_debouncer #(
    .NUM_KEYS       (NK),
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .keyIf (kIf)
  );

  key_debouncer_checker #(.NUM_KEYS(NK)) chk (
    .Clock        (Clock),
    .Reset        (Reset),
    .KeysClean    (kIf.KeysClean),
    .PressPulse   (kIf.PressPulse),
    .ReleasePulse (kIf.ReleasePulse)
  );

  always #5 Clock = ~Clock;

  int passCount  = 0;
  int checkCount = 0;

  // ---------------- reference model ----------------
  // Pin level reaches the debouncer two edges late. Once that delayed level
  // differs from the clean level, the edge that first notices it starts a
  // candidate; later tick edges are counted and the DT-th one accepts.
  logic [NK-1:0] mPipe1, mPipe2, mClean, mPress, mRelease;
  int            mPhase;
  bit            mPending [NK];
  int            mTicks   [NK];

  always @(posedge Clock) begin
    if (!Reset) begin
      mPipe1 = '1; mPipe2 = '1; mClean = '1; mPress = '0; mRelease = '0;
      mPhase = 0;
      for (int k = 0; k < NK; k++) begin mPending[k] = 1'b0; mTicks[k] = 0; end
    end else begin
      bit tickNow;
      tickNow  = (mPhase == TD - 1);
      mPress   = '0;
      mRelease = '0;
      for (int k = 0; k < NK; k++) begin
        if (!kIf.Enable) begin
          mClean[k] = 1'b1; mPending[k] = 1'b0;
        end else if (mPipe2[k] == mClean[k]) begin
          mPending[k] = 1'b0;
        end else if (!mPending[k]) begin
          mPending[k] = 1'b1; mTicks[k] = 0;
        end else if (tickNow) begin
          mTicks[k]++;
          if (mTicks[k] == DT) begin
            mClean[k] = ~mClean[k];
            if (mClean[k]) mRelease[k] = 1'b1; else mPress[k] = 1'b1;
            mPending[k] = 1'b0;
          end
        end
      end
      mPhase = kIf.Enable ? (mPhase + 1) % TD : 0;
      mPipe2 = mPipe1;
      mPipe1 = kIf.KeysRaw;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checkCount++;
    if (act >= lo && act <= hi) passCount++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // One clock; sample at the falling edge and compare against the model.
  task automatic stepCycle();
    @(posedge Clock);
    @(negedge Clock);
    checkVal("model", {kIf.KeysClean, kIf.PressPulse, kIf.ReleasePulse},
             {mClean, mPress, mRelease});
  endtask

  // Step until output (0 clean,1 press,2 release) bit equals val; -1 on timeout.
  task automatic waitBit(input int sel, input int bitIdx, input logic val,
                         input int limit, output int lat);
    logic cur;
    lat = -1;
    for (int c = 1; c <= limit; c++) begin
      stepCycle();
      case (sel)
        0:       cur = kIf.KeysClean[bitIdx];
        1:       cur = kIf.PressPulse[bitIdx];
        default: cur = kIf.ReleasePulse[bitIdx];
      endcase
      if (cur === val) begin
        lat = c;
        break;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] raw;
    int         cycles;
    logic [3:0] expClean;
    logic [3:0] expPress;
    logic [3:0] expRelease;
  } vec_t;

  vec_t vecs [8];
  int   holdLeft [NK];
  int   disLeft;
  int   lat;
  int   bad;

  initial begin
    kIf.Enable  = 1'b1;
    kIf.KeysRaw = 4'hF;
    Reset       = 1'b0;

    // Exact-timing table from reset (prescaler phase is known here).
    vecs[0] = '{1'b0, 1'b1, 4'hF,  3, 4'hF, 4'h0, 4'h0};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 50, 4'hF, 4'h0, 4'h0};
    vecs[2] = '{1'b1, 1'b1, 4'hE, 13, 4'hF, 4'h0, 4'h0};
    vecs[3] = '{1'b1, 1'b1, 4'hE,  1, 4'hE, 4'h1, 4'h0};
    vecs[4] = '{1'b1, 1'b1, 4'hE,  1, 4'hE, 4'h0, 4'h0};
    vecs[5] = '{1'b1, 1'b1, 4'hF, 14, 4'hE, 4'h0, 4'h0};
    vecs[6] = '{1'b1, 1'b1, 4'hF,  1, 4'hF, 4'h0, 4'h1};
    vecs[7] = '{1'b1, 1'b1, 4'hF,  1, 4'hF, 4'h0, 4'h0};

    for (int i = 0; i < 8; i++) begin
      Reset       = vecs[i].rst;
      kIf.Enable  = vecs[i].en;
      kIf.KeysRaw = vecs[i].raw;
      repeat (vecs[i].cycles) stepCycle();
      checkVal($sformatf("vec%0d clean", i),   kIf.KeysClean,    vecs[i].expClean);
      checkVal($sformatf("vec%0d press", i),   kIf.PressPulse,   vecs[i].expPress);
      checkVal($sformatf("vec%0d release", i), kIf.ReleasePulse, vecs[i].expRelease);
    end

    // Key 1 bounces every 5 cycles: never accepted, never pulses.
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      if (c < 60 && c % 5 == 0) kIf.KeysRaw[1] = ~kIf.KeysRaw[1];
      stepCycle();
      if (kIf.KeysClean[1] !== 1'b1 || kIf.PressPulse[1] !== 1'b0 || kIf.ReleasePulse[1] !== 1'b0)
        bad++;
    end
    checkVal("bounce key1 disturbances", bad, 0);
    checkVal("bounce key1 raw back high", kIf.KeysRaw[1], 1'b1);

    // Key 2 press then release; release latency and single-cycle pulse.
    kIf.KeysRaw[2] = 1'b0;
    waitBit(1, 2, 1'b1, 40, lat);
    checkRange("key2 press latency", lat, 12, 15);
    repeat (5) stepCycle();
    kIf.KeysRaw[2] = 1'b1;
    waitBit(0, 2, 1'b1, 40, lat);
    checkRange("key2 release latency", lat, 12, 15);
    checkVal("key2 release pulse", kIf.ReleasePulse, 4'b0100);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      if (kIf.ReleasePulse[2] !== 1'b0) bad++;
    end
    checkVal("key2 release pulse width", bad, 0);

    // Keys 0 and 3 pressed together: simultaneous acceptance.
    kIf.KeysRaw = 4'b0110;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      stepCycle();
      if (kIf.PressPulse !== 4'b0000) begin lat = c; break; end
    end
    checkRange("keys0+3 latency", lat, 12, 15);
    checkVal("keys0+3 press", kIf.PressPulse, 4'b1001);
    checkVal("keys0+3 clean", kIf.KeysClean, 4'b0110);
    kIf.KeysRaw = 4'hF;
    repeat (25) stepCycle();
    checkVal("keys0+3 released", kIf.KeysClean, 4'hF);

    // Enable drop with key 0 held, then a fresh debounce on re-enable.
    kIf.KeysRaw[0] = 1'b0;
    waitBit(1, 0, 1'b1, 40, lat);
    checkRange("key0 press before disable", lat, 12, 15);
    stepCycle();
    kIf.Enable = 1'b0;
    stepCycle();
    checkVal("disable clean", kIf.KeysClean, 4'hF);
    checkVal("disable pulses", {kIf.PressPulse, kIf.ReleasePulse}, 8'h00);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      if ({kIf.PressPulse, kIf.ReleasePulse} !== 8'h00 || kIf.KeysClean !== 4'hF) bad++;
    end
    checkVal("disabled quiet", bad, 0);
    kIf.Enable = 1'b1;
    waitBit(1, 0, 1'b1, 40, lat);
    checkRange("re-enable press latency", lat, 12, 15);
    kIf.KeysRaw = 4'hF;
    repeat (25) stepCycle();

    // Reset in the middle of a press debounce.
    kIf.KeysRaw[3] = 1'b0;
    repeat (6) stepCycle();
    checkVal("press wait clean", kIf.KeysClean, 4'hF);
    Reset = 1'b0;
    stepCycle();
    checkVal("mid reset outputs", {kIf.KeysClean, kIf.PressPulse, kIf.ReleasePulse}, 12'hF00);
    kIf.KeysRaw = 4'hF;
    Reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      stepCycle();
      if ({kIf.PressPulse, kIf.ReleasePulse} !== 8'h00) bad++;
    end
    checkVal("after reset no pulse", bad, 0);

    // Randomised pins, enable drops and rare resets against the model.
    for (int k = 0; k < NK; k++) holdLeft[k] = $urandom_range(1, 20);
    disLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (holdLeft[k] == 0) begin
          kIf.KeysRaw[k] = ~kIf.KeysRaw[k];
          holdLeft[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 30);
        end else begin
          holdLeft[k]--;
        end
      end
      if (disLeft > 0) begin
        disLeft--;
        kIf.Enable = (disLeft == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        kIf.Enable = 1'b0;
        disLeft = $urandom_range(1, 10);
      end
      Reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      stepCycle();
    end

    Reset       = 1'b1;
    kIf.Enable  = 1'b1;
    kIf.KeysRaw = 4'hF;
    repeat (40) stepCycle();
    checkVal("final idle clean", kIf.KeysClean, 4'hF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
